// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, via a minterm full adder.
// Ports: clk, rst (sync, active-high), start, a, b, cin -> busy, done, sum, cout.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [2:0] w_idx;
    logic [7:0] w_m;
    logic       w_sbit;
    logic       w_cnext;

    // One-hot minterm decode of {a, b, carry}
    assign w_idx   = {r_a[0], r_b[0], r_c};
    assign w_m     = 8'd1 << w_idx;
    assign w_sbit  = w_m[1] | w_m[2] | w_m[4] | w_m[7];
    assign w_cnext = w_m[3] | w_m[5] | w_m[6] | w_m[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Sum bits enter at the MSB; after WIDTH shifts
                    // the first bit lands at the LSB.
                    r_sum <= {w_sbit, r_sum[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cnext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_cnext;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
